// File: rtl/inst_fetch.sv
`default_nettype none
// inst_fetch: issues imem reads for the PC unit's fetch address and buffers returned bundles for decode.
// Optional same-cycle bypass of an empty FIFO when INST_FETCH_BYPASS_EN is defined. Rev 1.0
module inst_fetch #(
  parameter int ADDR_W  = 25,
  parameter int IMEM_AW = 14,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                flush,
  output logic                n_stall,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic [DATA_W-1:0]   inst,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pcs  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_fifo_valid;
  logic              w_pop;
  logic              w_fifo_pop;
  logic              w_push;
  logic [CNT_W:0]    w_occ;

  assign w_fifo_valid = (r_count != '0);
  // Outstanding read counts as occupied so a return can never overflow the FIFO.
  assign w_occ        = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);

`ifdef INST_FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp      = ~w_fifo_valid & r_inflight & ~flush;
  assign inst_valid = w_fifo_valid | w_byp;
  assign inst       = w_byp ? imem_rdata : r_data[r_head];
  assign inst_pc    = w_byp ? r_inflight_pc : (w_fifo_valid ? r_pcs[r_head] : '0);
  assign w_pop      = inst_valid & inst_ready & ~flush;
  assign w_fifo_pop = w_pop & w_fifo_valid;
  assign w_push     = r_inflight & ~flush & ~(w_byp & inst_ready);
`else
  assign inst_valid = w_fifo_valid;
  assign inst       = r_data[r_head];
  assign inst_pc    = w_fifo_valid ? r_pcs[r_head] : '0;
  assign w_pop      = w_fifo_valid & inst_ready & ~flush;
  assign w_fifo_pop = w_pop;
  assign w_push     = r_inflight & ~flush;
`endif

  assign n_stall   = flush | (w_occ < (CNT_W + 1)'(DEPTH)) | w_pop;
  assign imem_en   = n_stall & ~flush;
  assign imem_addr = pc[IMEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= imem_rdata;
      r_pcs[r_tail]  <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PTR_W'(1);
      if (w_fifo_pop)
        r_head <= r_head + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
      r_inflight <= imem_en;
      if (imem_en)
        r_inflight_pc <= pc;
    end
  end

endmodule
`default_nettype wire
